// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters; sequences init/finish and routes P back.
// Optional watchdog: define MULT_TIMEOUT_EN to abort an operation after TIMEOUT_CYC cycles in ARM/WAIT.
module mult_arbiter #(
  parameter int n           = 8,
  parameter int TIMEOUT_CYC = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [n-1:0]     req0_a,
  input  logic [n-1:0]     req0_b,
  input  logic [n-1:0]     req0_n,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [n-1:0]     req1_a,
  input  logic [n-1:0]     req1_b,
  input  logic [n-1:0]     req1_n,
  output logic             rsp0_valid,
  output logic [2*n-1:0]   rsp0_p,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [2*n-1:0]   rsp1_p,
  output logic             rsp1_err,
  output logic             mul_init,
  output logic [n-1:0]     mul_a,
  output logic [n-1:0]     mul_b,
  output logic [n-1:0]     mul_n,
  input  logic [2*n-1:0]   mul_p,
  input  logic             mul_finish,
  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_ARM   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   accept;
  logic   win;
  logic   done;
  logic   expire;
  logic   finish_any;

  // A limit below one cycle could never fire; reject it at elaboration.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // Handshake: a requester holds valid with stable operands until it sees ready;
  // operands are taken on the cycle valid & ready, and ready never depends on a
  // later cycle. Only one ready is raised per cycle; the ptr side wins a tie.
  assign req0_ready = (state == S_IDLE) && req0_valid && (!ptr || !req1_valid);
  assign req1_ready = (state == S_IDLE) && req1_valid && ( ptr || !req0_valid);
  assign accept     = req0_ready || req1_ready;
  assign win        = req1_ready;

  // Finish is only trusted in WAIT; in ARM it may still be the stale idle level.
  assign done       = (state == S_WAIT) && mul_finish;
  assign finish_any = done || expire;

  assign mul_init   = (state == S_START);
  assign busy       = (state != S_IDLE);

`ifdef MULT_TIMEOUT_EN
  localparam int cnt_w = $clog2(TIMEOUT_CYC + 1);

  logic [cnt_w-1:0] cnt;

  assign expire = ((state == S_ARM) || (state == S_WAIT)) &&
                  (cnt == cnt_w'(TIMEOUT_CYC - 1)) && !done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == S_START) begin
      cnt <= '0;
    end else if ((state == S_ARM) || (state == S_WAIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else if (finish_any) begin
      if (grant) rsp1_err <= expire;
      else       rsp0_err <= expire;
    end
  end
`else
  assign expire   = 1'b0;
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_ARM;
      S_ARM:   state_nxt = expire ? S_IDLE : S_WAIT;
      S_WAIT:  if (finish_any) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= 1'b0;
      grant <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      mul_n <= '0;
    end else if (accept) begin
      ptr   <= !win;
      grant <= win;
      mul_a <= win ? req1_a : req0_a;
      mul_b <= win ? req1_b : req0_b;
      mul_n <= win ? req1_n : req0_n;
    end
  end

  // A timed-out operation reports a zero result alongside its error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_p     <= '0;
      rsp1_p     <= '0;
    end else begin
      rsp0_valid <= finish_any && !grant;
      rsp1_valid <= finish_any &&  grant;
      if (finish_any && !grant) rsp0_p <= expire ? '0 : mul_p;
      if (finish_any &&  grant) rsp1_p <= expire ? '0 : mul_p;
    end
  end

endmodule
